gray_decoder_monitor: RTL and testbench
=======================================

GRAY_DECODER_MONITOR -- requirements
Module: gray_decoder_monitor

Interface
REQ-001 Parameter WIDTH, default 4: gray/binary word width; legal range 2..16.
REQ-002 Parameter LOCK_STEPS, default 4: consecutive good steps needed to enter LOCKED; legal range 1..15.
REQ-003 clk  input  1: single clock; all state updates on posedge clk.
REQ-004 rst_  input  1: reset is synchronous and active-low.
REQ-005 gray_in  input  WIDTH: gray-coded sample.
REQ-006 valid_in  input  1: gray_in is sampled on any posedge where valid_in=1.
REQ-007 clear_err  input  1: synchronous clear of err_count.
REQ-008 bin_out  output  WIDTH: registered binary decode of the last accepted sample.
REQ-009 bin_valid  output  1: one-cycle pulse; bin_out, dir_up, dir_dn, wrap, step_err are valid in this cycle.
REQ-010 dir_up / dir_dn  output  1 each: the accepted sample is +1 / -1 (mod 2^WIDTH) from the previous sample.
REQ-011 wrap  output  1: the step crossed the boundary between 2^WIDTH-1 and 0 in either direction.
REQ-012 step_err  output  1: the accepted sample is neither a hold, +1, nor -1 from the previous sample.
REQ-013 locked  output  1: the state machine is in LOCKED.
REQ-014 err_count  output  8: saturating count of step errors.

Function
REQ-015 Decode: bin[WIDTH-1]=gray[WIDTH-1]; bin[i]=bin[i+1]^gray[i] for each lower bit i.
REQ-016 Latency: a sample accepted at edge N appears on bin_out with bin_valid=1 after edge N+1; with back-to-back valid_in the block sustains one sample per cycle.
REQ-017 bin_valid=0 in any cycle that follows an edge with valid_in=0; bin_out then holds its value.
REQ-018 Step classification: delta=(bin_new-bin_prev) mod 2^WIDTH; 0 is a hold (no flags), 1 sets dir_up, 2^WIDTH-1 sets dir_dn, any other value sets step_err.
REQ-019 wrap=1 only together with dir_up where prev=2^WIDTH-1 and new=0, or with dir_dn where prev=0 and new=2^WIDTH-1.
REQ-020 The first sample accepted after reset has no comparison: all flags are 0 and only bin_out/bin_valid update.
REQ-021 FSM states: EMPTY (reset), TRACK, LOCKED; internal good_cnt is 4 bits.
REQ-022 EMPTY -> TRACK on the first accepted sample, with good_cnt=0.
REQ-023 TRACK: an up/down step increments good_cnt; if good_cnt reaches LOCK_STEPS the FSM enters LOCKED; an error clears good_cnt and stays in TRACK; a hold changes nothing.
REQ-024 LOCKED: an error moves the FSM to TRACK with good_cnt=0; steps and holds keep it in LOCKED.
REQ-025 locked is registered from the state and changes in the same cycle that bin_valid reports the causing sample.
REQ-026 err_count increments on each step_err and saturates at 255.
REQ-027 clear_err and a step_err on the same edge leave err_count=1.
REQ-028 clear_err alone sets err_count=0.

Reset
REQ-029 When rst_=0 at a posedge, the block sets state=EMPTY, good_cnt=0, the previous-sample register to 0, and bin_out=0; bin_valid, dir_up, dir_dn, wrap, step_err and locked go to 0; err_count goes to 0.
REQ-030 Reset takes precedence over valid_in and clear_err on the same edge; a sample presented during reset is discarded.
REQ-031 Reset asserted mid-stream makes the next accepted sample a first sample (REQ-020).

Configuration
REQ-032 Macro GRAY_DEC_ERR_CNT_EN defined: err_count and clear_err behave per REQ-026..028.
REQ-033 Macro GRAY_DEC_ERR_CNT_EN undefined: no counter logic is built, err_count is constant 0, and clear_err is ignored; every other behaviour is unchanged.

Verification
REQ-034 Reset, then feed gray 0,1,3,2,6 (binary 0..4) on consecutive cycles -> bin_out 0,1,2,3,4 one cycle later, dir_up=1 on the last four, locked=1 on the cycle that reports binary 4 (LOCK_STEPS=4).
REQ-035 Feed binary 15 then 0 (gray 8, then 0) -> dir_up=1 and wrap=1; then feed 15 -> dir_dn=1 and wrap=1.
REQ-036 While locked, feed binary 5 then 9 -> step_err=1, locked=0 on the same report cycle, err_count increments by 1.
REQ-037 Force 256 errors, then assert clear_err together with another error -> err_count 255 (saturated), then 1.
REQ-038 Stream samples, assert rst_=0 for one cycle, then feed binary 7 -> no flags, bin_out=7, state TRACK.
REQ-039 Build without GRAY_DEC_ERR_CNT_EN and repeat REQ-036 -> err_count stays 0 and all other outputs match the build with the macro defined.

Source files
------------

// File: rtl/gray_decoder_monitor.sv
// gray_decoder_monitor: gray-to-binary decoder with step classification and lock FSM.
// Define GRAY_DEC_ERR_CNT_EN to build the saturating err_count.
module gray_decoder_monitor #(
  parameter int WIDTH      = 4,
  parameter int LOCK_STEPS = 4
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             valid_in,
  input  logic             clear_err,
  output logic [WIDTH-1:0] bin_out,
  output logic             bin_valid,
  output logic             dir_up,
  output logic             dir_dn,
  output logic             wrap,
  output logic             step_err,
  output logic             locked,
  output logic [7:0]       err_count
);
  typedef enum logic [1:0] {EMPTY, TRACK, LOCKED} state_t;
  state_t state_q, state_d;
  logic [3:0] good_cnt_q, good_cnt_d, good_inc;
  logic [WIDTH-1:0] gray_q, gray_d, bin_q, bin_d, bin, delta;
  logic vld_q, vld_d, bin_valid_q, bin_valid_d, dir_up_q, dir_up_d, dir_dn_q, dir_dn_d;
  logic wrap_q, wrap_d, step_err_q, step_err_d, locked_q, locked_d;
  logic have, up, dn, err;
  for (genvar g = 0; g < WIDTH; g++) begin : g_dec
    assign bin[g] = ^(gray_q >> g);
  end
  always_comb begin
    gray_d      = valid_in ? gray_in : gray_q;
    vld_d       = valid_in;
    delta       = bin - bin_q;
    have        = vld_q && state_q != EMPTY;
    up          = have && delta == WIDTH'(1);
    dn          = have && delta == '1;
    err         = have && delta != '0 && !up && !dn;
    bin_d       = vld_q ? bin : bin_q;
    bin_valid_d = vld_q;
    dir_up_d    = up;
    dir_dn_d    = dn;
    wrap_d      = (up && bin_q == '1) || (dn && bin_q == '0);
    step_err_d  = err;
    good_inc    = good_cnt_q + 4'd1;
    state_d     = state_q;
    good_cnt_d  = good_cnt_q;
    if (vld_q)
      case (state_q)
        EMPTY: begin
          state_d    = TRACK;
          good_cnt_d = '0;
        end
        TRACK: begin
          good_cnt_d = err ? '0 : (up || dn) ? good_inc : good_cnt_q;
          state_d    = (!err && (up || dn) && good_inc >= 4'(LOCK_STEPS)) ? LOCKED : TRACK;
        end
        default: begin
          good_cnt_d = err ? '0 : good_cnt_q;
          state_d    = err ? TRACK : LOCKED;
        end
      endcase
    locked_d = state_d == LOCKED;
  end
  always_ff @(posedge clk) begin
    if (!rst_) begin
      state_q     <= EMPTY;
      good_cnt_q  <= '0;
      gray_q      <= '0;
      vld_q       <= 1'b0;
      bin_q       <= '0;
      bin_valid_q <= 1'b0;
      dir_up_q    <= 1'b0;
      dir_dn_q    <= 1'b0;
      wrap_q      <= 1'b0;
      step_err_q  <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      good_cnt_q  <= good_cnt_d;
      gray_q      <= gray_d;
      vld_q       <= vld_d;
      bin_q       <= bin_d;
      bin_valid_q <= bin_valid_d;
      dir_up_q    <= dir_up_d;
      dir_dn_q    <= dir_dn_d;
      wrap_q      <= wrap_d;
      step_err_q  <= step_err_d;
      locked_q    <= locked_d;
    end
  end
  assign bin_out   = bin_q;
  assign bin_valid = bin_valid_q;
  assign dir_up    = dir_up_q;
  assign dir_dn    = dir_dn_q;
  assign wrap      = wrap_q;
  assign step_err  = step_err_q;
  assign locked    = locked_q;
`ifdef GRAY_DEC_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;
  // clear wins over the old count but still counts an error on the same edge
  always_comb err_cnt_d = clear_err ? {7'd0, err} : (err && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
  always_ff @(posedge clk) begin
    if (!rst_) err_cnt_q <= '0;
    else err_cnt_q <= err_cnt_d;
  end
  assign err_count = err_cnt_q;
`else
  logic unused_clear_err;
  assign unused_clear_err = clear_err;
  assign err_count = '0;
`endif
endmodule

// File: tb/tb_gray_decoder_monitor.sv
// tb_gray_decoder_monitor: directed vectors for gray_decoder_monitor (WIDTH=4, LOCK_STEPS=4).
module tb_gray_decoder_monitor;
`ifdef GRAY_DEC_ERR_CNT_EN
  localparam bit EC = 1'b1;
`else
  localparam bit EC = 1'b0;
`endif
  logic clk = 1'b0, rst_ = 1'b0, valid_in = 1'b0, clear_err = 1'b0;
  logic [3:0] gray_in = '0, bin_out;
  logic bin_valid, dir_up, dir_dn, wrap, step_err, locked;
  logic [7:0] err_count;
  int n_chk = 0, n_pass = 0;
  gray_decoder_monitor #(.WIDTH(4), .LOCK_STEPS(4)) dut (
    .clk(clk), .rst_(rst_), .gray_in(gray_in), .valid_in(valid_in), .clear_err(clear_err),
    .bin_out(bin_out), .bin_valid(bin_valid), .dir_up(dir_up), .dir_dn(dir_dn), .wrap(wrap),
    .step_err(step_err), .locked(locked), .err_count(err_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [9:0] ev(input logic [3:0] b, input logic v, u, d, w, e, l);
    return {b, v, u, d, w, e, l};
  endfunction
  function automatic logic [9:0] obs();
    return {bin_out, bin_valid, dir_up, dir_dn, wrap, step_err, locked};
  endfunction
  logic [3:0] gin [16];
  logic [9:0] exp_o [16];
  int ec [16];
  initial begin
    // bin: 0 1 2 3 4 15 0 15 0 1 2 3 4 5 9 9
    gin   = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd8, 4'd0, 4'd8, 4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd13, 4'd13};
    exp_o = '{ev(0, 1, 0, 0, 0, 0, 0), ev(1, 1, 1, 0, 0, 0, 0), ev(2, 1, 1, 0, 0, 0, 0),
              ev(3, 1, 1, 0, 0, 0, 0), ev(4, 1, 1, 0, 0, 0, 1), ev(15, 1, 0, 0, 0, 1, 0),
              ev(0, 1, 1, 0, 1, 0, 0), ev(15, 1, 0, 1, 1, 0, 0), ev(0, 1, 1, 0, 1, 0, 0),
              ev(1, 1, 1, 0, 0, 0, 1), ev(2, 1, 1, 0, 0, 0, 1), ev(3, 1, 1, 0, 0, 0, 1),
              ev(4, 1, 1, 0, 0, 0, 1), ev(5, 1, 1, 0, 0, 0, 1), ev(9, 1, 0, 0, 0, 1, 0),
              ev(9, 1, 0, 0, 0, 0, 0)};
    ec    = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 2, 2};
    cyc();
    cyc();
    chk("rst_out", 32'(obs()), 32'(ev(0, 0, 0, 0, 0, 0, 0)));
    chk("rst_err", 32'(err_count), 0);
    rst_ = 1'b1;
    valid_in = 1'b1;
    for (int i = 0; i < 16; i++) begin
      gray_in = gin[i];
      cyc();
      if (i == 0) chk("first_lat", 32'(bin_valid), 0);
      else begin
        chk($sformatf("seq%0d", i - 1), 32'(obs()), 32'(exp_o[i - 1]));
        chk($sformatf("seq%0d_err", i - 1), 32'(err_count), EC ? ec[i - 1] : 0);
      end
    end
    valid_in = 1'b0;
    cyc();
    chk("seq15", 32'(obs()), 32'(exp_o[15]));
    cyc();
    chk("idle_hold", 32'(obs()), 32'(ev(9, 0, 0, 0, 0, 0, 0)));
    valid_in = 1'b1;
    for (int i = 0; i < 260; i++) begin
      gray_in = i[0] ? 4'd3 : 4'd0;
      cyc();
    end
    valid_in = 1'b0;
    cyc();
    chk("sat_out", 32'(obs()), 32'(ev(2, 1, 0, 0, 0, 1, 0)));
    chk("sat_err", 32'(err_count), EC ? 255 : 0);
    gray_in = 4'd0;
    valid_in = 1'b1;
    cyc();
    valid_in = 1'b0;
    clear_err = 1'b1;
    cyc();
    chk("clr_err_out", 32'(obs()), 32'(ev(0, 1, 0, 0, 0, 1, 0)));
    chk("clr_err_cnt", 32'(err_count), EC ? 1 : 0);
    cyc();
    chk("clr_only", 32'(err_count), 0);
    chk("clr_only_v", 32'(bin_valid), 0);
    clear_err = 1'b0;
    valid_in = 1'b1;
    gray_in = 4'd1;
    cyc();
    rst_ = 1'b0;
    gray_in = 4'd6;
    cyc();
    chk("mid_rst", 32'(obs()), 32'(ev(0, 0, 0, 0, 0, 0, 0)));
    rst_ = 1'b1;
    gray_in = 4'd4;
    cyc();
    chk("rst_discard", 32'(obs()), 32'(ev(0, 0, 0, 0, 0, 0, 0)));
    gray_in = 4'd12;
    cyc();
    chk("post_rst_first", 32'(obs()), 32'(ev(7, 1, 0, 0, 0, 0, 0)));
    valid_in = 1'b0;
    cyc();
    chk("post_rst_track", 32'(obs()), 32'(ev(8, 1, 1, 0, 0, 0, 0)));
    chk("post_rst_err", 32'(err_count), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
